uart_rx: RTL and testbench

Oversampling UART receiver: the receive end of the link clocked by the baud tick generator. It consumes the generator's single-cycle `tick` (16× the bit rate) and deframes an asynchronous serial line: start bit, DBIT data bits LSB-first, optional parity, then stop bit(s). It presents each received word with a one-cycle done strobe plus framing and parity status. It sits between the pad-side `rx` pin and the host-side receive FIFO.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - FSM state encoding (3-bit) and the state enum built on it
//   - parity mode constants
//   - oversampling constants
//   - parity_error(): receive-side parity check for a given mode
package uart_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_PAR   = S_PAR,
    ST_STOP  = S_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int         OVERSAMPLE = 16;
  localparam logic [4:0] MID_TICK   = 5'd7;

  // data_xor is the XOR reduction of the data word, p the received parity bit.
  function automatic logic parity_error(input int mode, input logic data_xor,
                                        input logic p);
    logic err;
    case (mode)
      PAR_EVEN: err = data_xor ^ p;
      PAR_ODD:  err = ~(data_xor ^ p);
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  in   destination clock
//   rst  in   async reset, active-high; both flops load RST_VAL
//   d    in   asynchronous input
//   q    out  synchronized output, 2 clk latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver (start, DBIT data LSB-first,
// optional parity, stop). Presents each word with a one-cycle done strobe
// and framing/parity status that hold until the next word.
// Ports:
//   clk           in   system clock
//   rst           in   async reset, active-high
//   tick          in   oversample strobe, 16 per bit, one clk wide
//   rx            in   asynchronous serial line, idle high
//   dout          out  last received word
//   rx_done_tick  out  one-cycle pulse when dout/flags update
//   frame_err     out  stop-bit sample was 0 in the last frame
//   parity_err    out  parity mismatch in the last frame (0 when PARITY=0)
//   busy          out  FSM not in IDLE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for rx_s low (not tick-qualified)
// START   | counting to mid start bit; low there = real start, else glitch
// DATA    | sampling DBIT data bits every 16 ticks at mid bit
// PAR     | sampling the parity bit
// STOP    | waiting SB_TICK ticks, then publishing word and status
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

  logic            rx_s;
  uart_state_t     state, state_n;
  logic [4:0]      s_cnt, s_cnt_n;
  logic [2:0]      n_cnt, n_cnt_n;
  logic [DBIT-1:0] b, b_n;
  logic            p, p_n;
  logic [DBIT-1:0] dout_n;
  logic            done_n, ferr_n, perr_n;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b            <= '0;
      p            <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      state        <= state_n;
      s_cnt        <= s_cnt_n;
      n_cnt        <= n_cnt_n;
      b            <= b_n;
      p            <= p_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
      parity_err   <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    b_n     = b;
    p_n     = p;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = frame_err;
    perr_n  = parity_err;

    case (state)
      ST_IDLE: begin
        // Start edge is taken on any clk; a coincident tick is not counted.
        if (!rx_s) begin
          state_n = ST_START;
          s_cnt_n = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (s_cnt == MID_TICK) begin
            if (!rx_s) begin
              state_n = ST_DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s_cnt == LAST_TICK) begin
            s_cnt_n = '0;
            b_n     = {rx_s, b[DBIT-1:1]};
            if (n_cnt == LAST_BIT) begin
              state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end else begin
              n_cnt_n = n_cnt + 3'd1;
            end
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end

      ST_PAR: begin
        if (tick) begin
          if (s_cnt == LAST_TICK) begin
            p_n     = rx_s;
            s_cnt_n = '0;
            state_n = ST_STOP;
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s_cnt == STOP_LAST) begin
            state_n = ST_IDLE;
            dout_n  = b;
            done_n  = 1'b1;
            ferr_n  = ~rx_s;
            perr_n  = parity_error(PARITY, ^b, p);
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Three receivers share clk,
// rst and tick but each has its own rx line: PARITY none / even / odd.
// Frames are bit-banged on the line at 16 ticks per bit; every done pulse is
// captured into a queue and compared with table constants or with a
// frame-level model (popcount parity, stop-bit level).
module tb_uart_rx;

  localparam int TICK_DIV = 8;
  localparam int BIT_CLK  = 16 * TICK_DIV;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } rec_t;

  typedef struct {
    string      name;
    int         inst;
    logic [7:0] data;
    logic       pbit;
    bit         stop_ok;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [7:0] dout [3];
  logic       done [3];
  logic       ferr [3];
  logic       perr [3];
  logic       busy [3];

  int   n_chk = 0;
  int   n_fail = 0;
  rec_t got_q[$];
  bit   prev_done [3];
  int   tcnt = 0;
  vec_t tbl [7];

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_none (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx[0]), .dout(dout[0]),
    .rx_done_tick(done[0]), .frame_err(ferr[0]), .parity_err(perr[0]),
    .busy(busy[0])
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_even (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx[1]), .dout(dout[1]),
    .rx_done_tick(done[1]), .frame_err(ferr[1]), .parity_err(perr[1]),
    .busy(busy[1])
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_odd (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx[2]), .dout(dout[2]),
    .rx_done_tick(done[2]), .frame_err(ferr[2]), .parity_err(perr[2]),
    .busy(busy[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tcnt == TICK_DIV - 1) begin
      tcnt <= 0;
      tick <= 1'b1;
    end else begin
      tcnt <= tcnt + 1;
      tick <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture every done pulse; a pulse must never be two cycles wide.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        rec_t r;
        chk("done_width", 32'(prev_done[i]), 32'd0);
        r.inst = i;
        r.data = dout[i];
        r.fe   = ferr[i];
        r.pe   = perr[i];
        got_q.push_back(r);
      end
      prev_done[i] = (done[i] === 1'b1);
    end
  end

  function automatic rec_t model(input int inst, input logic [7:0] d,
                                 input logic pbit, input bit stop_ok);
    rec_t r;
    int   ones;
    r.inst = inst;
    r.data = d;
    r.fe   = !stop_ok;
    ones   = $countones(d) + ((inst != 0) ? int'(pbit) : 0);
    case (inst)
      0:       r.pe = 1'b0;
      1:       r.pe = (ones % 2) != 0;
      default: r.pe = (ones % 2) == 0;
    endcase
    return r;
  endfunction

  // One frame on rx[inst]. A failed stop bit is held low only past its
  // mid-bit sample, so the receiver sees a short low that it rejects as a
  // glitch instead of a phantom start bit.
  task automatic send(input int inst, input logic [7:0] d, input logic pbit,
                      input bit stop_ok);
    rx[inst] = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[inst] = d[i];
      repeat (BIT_CLK) @(negedge clk);
      if (i == 0) chk("busy_mid_frame", 32'(busy[inst]), 32'd1);
    end
    if (inst != 0) begin
      rx[inst] = pbit;
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_ok) begin
      rx[inst] = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      rx[inst] = 1'b0;
      repeat (10 * TICK_DIV) @(negedge clk);
      rx[inst] = 1'b1;
      repeat (6 * TICK_DIV) @(negedge clk);
    end
  endtask

  task automatic check_one(input string name, input rec_t e);
    chk({name, "_count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      rec_t g;
      g = got_q.pop_front();
      chk({name, "_inst"}, 32'(g.inst), 32'(e.inst));
      chk({name, "_dout"}, 32'(g.data), 32'(e.data));
      chk({name, "_frame_err"}, 32'(g.fe), 32'(e.fe));
      chk({name, "_parity_err"}, 32'(g.pe), 32'(e.pe));
    end
    chk({name, "_dout_hold"}, 32'(dout[e.inst]), 32'(e.data));
    chk({name, "_busy_after"}, 32'(busy[e.inst]), 32'd0);
    got_q.delete();
  endtask

  task automatic run_frame(input string name, input int inst,
                           input logic [7:0] d, input logic pbit,
                           input bit stop_ok, input rec_t e);
    got_q.delete();
    send(inst, d, pbit, stop_ok);
    rx[inst] = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check_one(name, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t e;
    logic [7:0] seq [3];

    tbl[0] = '{"clean_a5", 0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{"ferr_3c",  0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{"clean_01", 0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{"even_ok",  1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{"even_bad", 1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{"odd_ok",   2, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{"odd_bad",  2, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_dout", 32'(dout[i]), 32'd0);
      chk("reset_done", 32'(done[i]), 32'd0);
      chk("reset_frame_err", 32'(ferr[i]), 32'd0);
      chk("reset_parity_err", 32'(perr[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (BIT_CLK) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      e = '{tbl[k].inst, tbl[k].data, tbl[k].exp_fe, tbl[k].exp_pe};
      run_frame(tbl[k].name, tbl[k].inst, tbl[k].data, tbl[k].pbit,
                tbl[k].stop_ok, e);
    end

    // Glitch: 6 ticks low never reaches the mid start-bit sample.
    got_q.delete();
    rx[0] = 1'b0;
    repeat (6 * TICK_DIV) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("glitch_no_done", 32'(got_q.size()), 32'd0);
    chk("glitch_busy", 32'(busy[0]), 32'd0);
    chk("glitch_dout_hold", 32'(dout[0]), 32'h01);

    // Back-to-back frames, no idle between stop and next start.
    got_q.delete();
    seq[0] = 8'h55;
    seq[1] = 8'hAA;
    seq[2] = 8'hFF;
    for (int k = 0; k < 3; k++) send(0, seq[k], 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    chk("b2b_count", 32'(got_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (got_q.size() > 0) begin
        rec_t g;
        g = got_q.pop_front();
        chk("b2b_dout", 32'(g.data), 32'(seq[k]));
        chk("b2b_frame_err", 32'(g.fe), 32'd0);
      end
    end
    got_q.delete();

    // Reset during data bit 4; held until the partial frame has ended.
    fork
      send(0, 8'h81, 1'b0, 1'b1);
      begin
        repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_dout", 32'(dout[0]), 32'd0);
        chk("rst_mid_done", 32'(done[0]), 32'd0);
        chk("rst_mid_frame_err", 32'(ferr[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
      end
    join
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    chk("rst_mid_no_done", 32'(got_q.size()), 32'd0);
    run_frame("after_rst_81", 0, 8'h81, 1'b0, 1'b1,
              model(0, 8'h81, 1'b0, 1'b1));

    // Randomized frames against the frame-level model.
    for (int k = 0; k < 6; k++) begin
      int         inst;
      logic [7:0] d;
      logic       pbit;
      bit         stop_ok;
      inst    = $urandom_range(0, 2);
      d       = 8'($urandom);
      pbit    = 1'($urandom_range(0, 1));
      stop_ok = ($urandom_range(0, 3) != 0);
      run_frame("rand", inst, d, pbit, stop_ok, model(inst, d, pbit, stop_ok));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
